// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_fetch_pkg : shared types and sizing helpers for the fetch queue.
// Rev 1.0
// ----------------------------------------------------------------------------
package mips_fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'hbfc0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_entry_t;

  function automatic int unsigned fetch_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned fetch_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_fetch_queue_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_fetch_queue_if : instruction SRAM port plus ID-stage valid/ready port.
// Rev 1.0
// ----------------------------------------------------------------------------
interface mips_fetch_queue_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;

  modport master (
    output inst_req, inst_addr, out_valid, out_pc, out_inst, out_adel,
    input  inst_addr_ok, inst_data_ok, inst_rdata, out_ready
  );

  modport slave (
    input  inst_req, inst_addr, out_valid, out_pc, out_inst, out_adel,
    output inst_addr_ok, inst_data_ok, inst_rdata, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/fetch_sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_sync_fifo : synchronous FIFO with flush; head reads 0 while empty.
// Rev 1.0
// ----------------------------------------------------------------------------
module fetch_sync_fifo
  import mips_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush_i,
  input  logic                             push_i,
  input  logic [WIDTH-1:0]                 din_i,
  input  logic                             pop_i,
  output logic [WIDTH-1:0]                 dout_o,
  output logic [fetch_cnt_w(DEPTH)-1:0]    count_o
);
  localparam int unsigned PTR_W = fetch_ptr_w(DEPTH);
  localparam int unsigned CNT_W = fetch_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths (e.g. 3 outstanding) correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign dout_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/mips_fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_fetch_queue : pipelined instruction fetch with decoupling queue.
// FETCH_QUEUE_ADEL_EN adds the misaligned-PC address-error path.  Rev 1.0
// ----------------------------------------------------------------------------
module mips_fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = FETCH_RESET_PC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  mips_fetch_queue_if.master   bus
);
  localparam int unsigned QCNT_W = fetch_cnt_w(DEPTH);
  localparam int unsigned OCNT_W = fetch_cnt_w(MAX_OUTST);

  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [OCNT_W-1:0] discard_q, discard_d;
  logic [QCNT_W-1:0] q_count;
  logic [OCNT_W-1:0] f_count;
  logic [31:0]       f_dout;
  fetch_entry_t      q_din, q_dout;
  logic              credit, hs, q_push, q_pop, adel_push;

  // Counting in-flight requests against queue space means a response always finds room.
  assign credit = !reset && !redirect_valid
               && ((32'(q_count) + 32'(f_count)) < DEPTH)
               && (32'(f_count) < MAX_OUTST);

`ifdef FETCH_QUEUE_ADEL_EN
  logic misaligned;
  logic adel_sent_q, adel_sent_d;

  assign misaligned    = fetch_pc_q[1:0] != 2'b00;
  assign bus.inst_req  = credit && !misaligned;
  assign bus.inst_addr = fetch_pc_q;
  assign adel_push     = credit && misaligned && !adel_sent_q && (f_count == '0);

  always_comb begin
    adel_sent_d = adel_sent_q;
    if (redirect_valid) adel_sent_d = 1'b0;
    else if (adel_push) adel_sent_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) adel_sent_q <= 1'b0;
    else       adel_sent_q <= adel_sent_d;
  end
`else
  assign bus.inst_req  = credit;
  assign bus.inst_addr = fetch_pc_q & ~32'h3;
  assign adel_push     = 1'b0;
`endif

  assign hs     = bus.inst_req && bus.inst_addr_ok;
  assign q_push = (bus.inst_data_ok && (discard_q == '0) && !redirect_valid) || adel_push;
  assign q_din  = adel_push ? '{pc: fetch_pc_q, inst: 32'h0, adel: 1'b1}
                            : '{pc: f_dout, inst: bus.inst_rdata, adel: 1'b0};
  assign q_pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      // Everything still in flight after this cycle belongs to the old stream.
      discard_d  = OCNT_W'(32'(f_count) + 32'(hs) - 32'(bus.inst_data_ok));
    end else begin
      if (hs) fetch_pc_d = fetch_pc_q + 32'd4;
      if (bus.inst_data_ok && (discard_q != '0)) discard_d = discard_q - OCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  fetch_sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (q_push),
    .din_i   (q_din),
    .pop_i   (q_pop),
    .dout_o  (q_dout),
    .count_o (q_count)
  );

  fetch_sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTST)
  ) u_inflight (
    .clk     (clk),
    .reset   (reset),
    .flush_i (1'b0),
    .push_i  (hs),
    .din_i   (bus.inst_addr),
    .pop_i   (bus.inst_data_ok),
    .dout_o  (f_dout),
    .count_o (f_count)
  );

  assign bus.out_valid = q_count != '0;
  assign bus.out_pc    = q_dout.pc;
  assign bus.out_inst  = q_dout.inst;
  assign bus.out_adel  = q_dout.adel;

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_queue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mips_fetch_queue : randomized SRAM/ID traffic against a stream-level model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mips_fetch_queue;
  import mips_fetch_pkg::*;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'hbfc0_0000;
`ifdef FETCH_QUEUE_ADEL_EN
  localparam bit ADEL = 1'b1;
`else
  localparam bit ADEL = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    int          stream;
    int          ready;
  } req_t;

  logic        clk            = 1'b0;
  logic        reset          = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;

  mips_fetch_queue_if bus ();

  mips_fetch_queue #(
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  req_t        pend[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc = 0, stream = 0, occ = 0;
  int          hs_count = 0, pop_count = 0, adel_seen = 0, first_valid = -1;
  logic [31:0] exp_pc     = RESET_PC;
  logic [31:0] fetch_addr = RESET_PC;
  bit          adel_sent  = 1'b0;
  int          addr_ok_pct = 100;
  int          max_dly     = 0;
  bit          hold_resp   = 1'b0;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1; redirect_valid = 1'b0; bus.out_ready = 1'b0;
      bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
      #1;
      check("rst_inst_req", 32'(bus.inst_req), 32'd0);
      if (i > 0) begin
        check("rst_inst_addr", bus.inst_addr, RESET_PC);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_pc", bus.out_pc, 32'd0);
        check("rst_out_inst", bus.out_inst, 32'd0);
        check("rst_out_adel", 32'(bus.out_adel), 32'd0);
      end
      cyc++;
    end
    pend.delete();
    occ = 0; stream++; adel_sent = 1'b0;
    fetch_addr = RESET_PC; exp_pc = RESET_PC;
  endtask

  // One clock: drive inputs, compare against the stream model, then advance the model.
  task automatic step(input bit rdr, input logic [31:0] rpc, input bit rdy);
    bit          dok, exp_req, misal, adel_push, live;
    logic [31:0] exp_inst;
    @(negedge clk);
    reset = 1'b0; redirect_valid = rdr; redirect_pc = rpc; bus.out_ready = rdy;
    bus.inst_addr_ok = ($urandom_range(99) < addr_ok_pct);
    dok = 1'b0;
    if (!hold_resp && pend.size() > 0) dok = (pend[0].ready <= cyc);
    bus.inst_data_ok = dok;
    bus.inst_rdata   = dok ? memword(pend[0].addr) : $urandom();
    #1;
    misal     = ADEL && (fetch_addr[1:0] != 2'b00);
    exp_req   = !rdr && ((occ + pend.size()) < DEPTH) && (pend.size() < MAX_OUTST) && !misal;
    adel_push = misal && !rdr && !adel_sent && (pend.size() == 0) && (occ < DEPTH);
    check("inst_req", 32'(bus.inst_req), 32'(exp_req));
    if (exp_req) check("inst_addr", bus.inst_addr, fetch_addr);
    check("out_valid", 32'(bus.out_valid), 32'(occ > 0));
    if (occ > 0) begin
      exp_inst = (exp_pc[1:0] != 2'b00) ? 32'h0 : memword(exp_pc);
      check("out_pc", bus.out_pc, exp_pc);
      check("out_inst", bus.out_inst, exp_inst);
      check("out_adel", 32'(bus.out_adel), 32'(exp_pc[1:0] != 2'b00));
      if (rdy) begin
        occ--;
        exp_pc += 32'd4;
      end
    end
    if (bus.out_valid && rdy) begin
      pop_count++;
      if (bus.out_adel) adel_seen++;
    end
    if (bus.out_valid && first_valid < 0) first_valid = cyc;
    live = 1'b0;
    if (dok) begin
      live = (pend[0].stream == stream) && !rdr;
      void'(pend.pop_front());
    end
    if (bus.inst_req && bus.inst_addr_ok) begin
      pend.push_back('{addr: bus.inst_addr, stream: stream,
                       ready: cyc + 1 + int'($urandom_range(max_dly))});
      fetch_addr += 32'd4;
      hs_count++;
    end
    if (live) occ++;
    if (adel_push) begin
      occ++;
      adel_sent = 1'b1;
    end
    if (rdr) begin
      occ = 0; stream++; adel_sent = 1'b0;
      fetch_addr = ADEL ? rpc : (rpc & ~32'h3);
      exp_pc     = fetch_addr;
    end
    check("outst_bound", 32'(pend.size() <= MAX_OUTST), 32'd1);
    check("count_bound", 32'(occ <= DEPTH), 32'd1);
    cyc++;
  endtask

  initial begin
    int          rel;
    int          rd;
    logic [31:0] t;
    bus.out_ready = 1'b0; bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
    do_reset(3);

    // Zero-wait streaming from reset.
    rel = cyc; first_valid = -1; pop_count = 0;
    repeat (20) step(1'b0, 32'h0, 1'b1);
    check("first_valid_lat", 32'(first_valid - rel), 32'd2);
    check("throughput", 32'(pop_count), 32'd18);

    // Stall fills the queue, then resume, then redirect latency from an idle SRAM.
    do_reset(2);
    hs_count = 0;
    repeat (10) step(1'b0, 32'h0, 1'b0);
    check("stall_reqs", 32'(hs_count), 32'(DEPTH));
    repeat (8) step(1'b0, 32'h0, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b0);
    rd = cyc;
    step(1'b1, 32'h8000_0100, 1'b1);
    first_valid = -1;
    repeat (8) step(1'b0, 32'h0, 1'b1);
    check("redirect_lat", 32'(first_valid - rd), 32'd3);

    // Redirect with two responses still pending.
    do_reset(2);
    hold_resp = 1'b1;
    repeat (3) step(1'b0, 32'h0, 1'b1);
    check("pending_at_redirect", 32'(pend.size()), 32'd2);
    step(1'b1, 32'h8000_1000, 1'b1);
    hold_resp = 1'b0;
    repeat (12) step(1'b0, 32'h0, 1'b1);

    // Redirects landing on live responses, back to back, and across the 2^32 wrap.
    repeat (6) step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hffff_fff8, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'hffff_fff4, 1'b1);
    repeat (12) step(1'b0, 32'h0, 1'b1);

    // Misaligned redirect target.
    step(1'b1, 32'h8000_0002, 1'b1);
    adel_seen = 0;
    repeat (8) step(1'b0, 32'h0, 1'b1);
    check("adel_entries", 32'(adel_seen), ADEL ? 32'd1 : 32'd0);
    step(1'b1, 32'h8000_2000, 1'b1);

    // Random SRAM latency, backpressure and redirects.
    addr_ok_pct = 60; max_dly = 5;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset(2);
      if ($urandom_range(99) < 4) begin
        t = $urandom();
        if ($urandom_range(7) != 0) t[1:0] = 2'b00;
        step(1'b1, t, $urandom_range(3) != 0);
      end else begin
        step(1'b0, 32'h0, $urandom_range(3) != 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
